// File: rtl/dram_cmd_pkg.sv
// Shared command/pin/state tables for the DRAM command bus decoder.
// Also used by controller-side state machines so both ends agree.
package dram_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_ILL = 3'd7
  } cmd_e;

  localparam logic [2:0] PIN_NOP = 3'b111;
  localparam logic [2:0] PIN_ACT = 3'b011;
  localparam logic [2:0] PIN_RD  = 3'b101;
  localparam logic [2:0] PIN_WR  = 3'b100;
  localparam logic [2:0] PIN_PRE = 3'b010;
  localparam logic [2:0] PIN_REF = 3'b000;
  localparam logic [2:0] PIN_MRS = 3'b001;
  localparam logic [2:0] PIN_ILL = 3'b110;

  typedef enum logic [1:0] {
    ST_CLOSED   = 2'd0,
    ST_OPEN     = 2'd1,
    ST_REF_BUSY = 2'd2
  } bank_st_e;

  function automatic cmd_e decode(
    input logic       cs_n,
    input logic [2:0] rcw
  );
    cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case (rcw)
        PIN_NOP: c = CMD_NOP;
        PIN_ACT: c = CMD_ACT;
        PIN_RD:  c = CMD_RD;
        PIN_WR:  c = CMD_WR;
        PIN_PRE: c = CMD_PRE;
        PIN_REF: c = CMD_REF;
        PIN_MRS: c = CMD_MRS;
        default: c = CMD_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_cmd_timer.sv
// Loadable down-counter; done strikes on the cycle the count leaves 1.
// zero reports an expired (or saturated) counter.
module dram_cmd_timer #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  assign zero = (count == '0);
  assign done = en && !load
             && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dram_cmd_decoder.sv
// DRAM command bus receiver: decode, bank/refresh tracking, violations.
// Optional REF_INTERVAL_CHECK_EN adds the viol_refi interval monitor.
module dram_cmd_decoder
  import dram_cmd_pkg::*;
#(
  parameter int T_RFC      = 104,
  parameter int T_REFI_MAX = 7800,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             RAS,
  input  logic             CAS,
  input  logic             WE,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic             row_open,
  output logic             ref_busy,
  output logic             ref_done,
  output logic [CNT_W-1:0] ref_count,
  output logic             viol_cmd,
  output logic             viol_state,
  output logic             viol_illegal
`ifdef REF_INTERVAL_CHECK_EN
  ,
  output logic             viol_refi
`endif
);

  bank_st_e state, state_nxt;
  cmd_e     cmd;
  logic     accept_ref;
  logic     set_cmd;
  logic     set_state;
  logic     rfc_done;
  logic     unused_rfc_zero;

  assign cmd      = decode(CS, {RAS, CAS, WE});
  assign row_open = (state == ST_OPEN);
  assign ref_busy = (state == ST_REF_BUSY);

  dram_cmd_timer #(
    .CNT_W (CNT_W)
  ) u_rfc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_ref),
    .load_val (CNT_W'(T_RFC)),
    .en       (ref_busy),
    .done     (rfc_done),
    .zero     (unused_rfc_zero)
  );

  always_comb begin
    state_nxt  = state;
    accept_ref = 1'b0;
    set_cmd    = 1'b0;
    set_state  = 1'b0;
    unique case (state)
      ST_CLOSED: begin
        unique case (1'b1)
          cmd == CMD_ACT: state_nxt = ST_OPEN;
          cmd == CMD_REF: begin
            state_nxt  = ST_REF_BUSY;
            accept_ref = 1'b1;
          end
          cmd == CMD_RD,
          cmd == CMD_WR:  set_state = 1'b1;
          default: ;
        endcase
      end
      ST_OPEN: begin
        unique case (1'b1)
          cmd == CMD_PRE: state_nxt = ST_CLOSED;
          cmd == CMD_ACT,
          cmd == CMD_REF,
          cmd == CMD_MRS: set_state = 1'b1;
          default: ;
        endcase
      end
      ST_REF_BUSY: begin
        set_cmd = (cmd != CMD_NOP);
        if (rfc_done) state_nxt = ST_CLOSED;
      end
      default: state_nxt = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_CLOSED;
      cmd_valid    <= 1'b0;
      cmd_code     <= 3'd0;
      ref_done     <= 1'b0;
      ref_count    <= '0;
      viol_cmd     <= 1'b0;
      viol_state   <= 1'b0;
      viol_illegal <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd_valid    <= (cmd != CMD_NOP);
      cmd_code     <= cmd;
      ref_done     <= rfc_done;
      if (accept_ref) ref_count <= ref_count + 1'b1;
      viol_cmd     <= viol_cmd | set_cmd;
      viol_state   <= viol_state | set_state;
      viol_illegal <= viol_illegal
                    | (cmd == CMD_ILL);
    end
  end

`ifdef REF_INTERVAL_CHECK_EN
  // Down-count from T_REFI_MAX+1; reaching zero means the gap was exceeded.
  localparam logic [CNT_W-1:0] REFI_TOP =
    CNT_W'(T_REFI_MAX + 1);

  logic refi_zero;
  logic unused_refi_done;

  dram_cmd_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (REFI_TOP)
  ) u_refi (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_ref),
    .load_val (REFI_TOP),
    .en       (!ref_busy),
    .done     (unused_refi_done),
    .zero     (refi_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) viol_refi <= 1'b0;
    else        viol_refi <= viol_refi | refi_zero;
  end
`endif

endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Scoreboard bench for dram_cmd_decoder.
// Build with REF_INTERVAL_CHECK_EN to also cover viol_refi.
module tb_dram_cmd_decoder;

  localparam int T_RFC = 104;
  localparam int T_REFI_MAX = 20;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_DES = 4'b1000;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0000;
  localparam logic [3:0] P_MRS = 4'b0001;
  localparam logic [3:0] P_ILL = 4'b0110;

  logic clk = 1'b0;
  logic rst_n, CS, RAS, CAS, WE;
  logic cmd_valid, row_open, ref_busy, ref_done;
  logic [2:0] cmd_code;
  logic [15:0] ref_count;
  logic viol_cmd, viol_state, viol_illegal;
`ifdef REF_INTERVAL_CHECK_EN
  logic viol_refi;
`endif

  always #5 clk = ~clk;

  dram_cmd_decoder #(
    .T_RFC      (T_RFC),
    .T_REFI_MAX (T_REFI_MAX),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CS           (CS),
    .RAS          (RAS),
    .CAS          (CAS),
    .WE           (WE),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .row_open     (row_open),
    .ref_busy     (ref_busy),
    .ref_done     (ref_done),
    .ref_count    (ref_count),
    .viol_cmd     (viol_cmd),
    .viol_state   (viol_state),
    .viol_illegal (viol_illegal)
`ifdef REF_INTERVAL_CHECK_EN
    ,
    .viol_refi    (viol_refi)
`endif
  );

  typedef struct {
    logic        valid;
    logic [2:0]  code;
    logic        row;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic        vc;
    logic        vs;
    logic        vi;
    logic        vr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_seen = 0;
  int done_seen = 0;

  // Reference model state: 0 closed, 1 open, 2 refresh busy
  int m_st = 0, m_left = 0, m_icnt = 0;
  logic [15:0] m_cnt = '0;
  logic m_vc = 0, m_vs = 0, m_vi = 0, m_vr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r,
                       input logic [3:0] p,
                       output exp_t e);
    int  code;
    bit  acc;
    bit  busy_before;
    case (p[2:0])
      3'b111: code = 0;
      3'b011: code = 1;
      3'b101: code = 2;
      3'b100: code = 3;
      3'b010: code = 4;
      3'b000: code = 5;
      3'b001: code = 6;
      default: code = 7;
    endcase
    if (p[3]) code = 0;
    e.done = 1'b0;
    if (!r) begin
      m_st = 0; m_left = 0; m_cnt = '0; m_icnt = 0;
      m_vc = 0; m_vs = 0; m_vi = 0; m_vr = 0;
      code = 0;
    end else begin
      acc = 0;
      busy_before = (m_st == 2);
      if (m_icnt > T_REFI_MAX) m_vr = 1;
      case (m_st)
        0: begin
          if (code == 1) m_st = 1;
          else if (code == 5) begin
            m_st = 2; m_left = T_RFC;
            m_cnt = m_cnt + 16'd1; acc = 1;
          end else if (code == 2 || code == 3) m_vs = 1;
        end
        1: begin
          if (code == 4) m_st = 0;
          else if (code == 1 || code == 5 || code == 6)
            m_vs = 1;
        end
        default: begin
          if (code != 0) m_vc = 1;
          m_left--;
          if (m_left == 0) begin
            m_st = 0; e.done = 1'b1;
          end
        end
      endcase
      if (code == 7) m_vi = 1;
      if (acc) m_icnt = 0;
      else if (!busy_before && m_icnt < 65535) m_icnt++;
    end
    e.valid = (code != 0);
    e.code  = 3'(code);
    e.row   = (m_st == 1);
    e.busy  = (m_st == 2);
    e.cnt   = m_cnt;
    e.vc = m_vc; e.vs = m_vs; e.vi = m_vi; e.vr = m_vr;
  endtask

  task automatic step(input logic r, input logic [3:0] p);
    exp_t e, o;
    rst_n = r;
    {CS, RAS, CAS, WE} = p;
    model(r, p, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    busy_seen += int'(ref_busy);
    done_seen += int'(ref_done);
    chk("cmd_valid", 32'(cmd_valid), 32'(o.valid));
    chk("cmd_code", 32'(cmd_code), 32'(o.code));
    chk("row_open", 32'(row_open), 32'(o.row));
    chk("ref_busy", 32'(ref_busy), 32'(o.busy));
    chk("ref_done", 32'(ref_done), 32'(o.done));
    chk("ref_count", 32'(ref_count), 32'(o.cnt));
    chk("viol_cmd", 32'(viol_cmd), 32'(o.vc));
    chk("viol_state", 32'(viol_state), 32'(o.vs));
    chk("viol_illegal", 32'(viol_illegal), 32'(o.vi));
`ifdef REF_INTERVAL_CHECK_EN
    chk("viol_refi", 32'(viol_refi), 32'(o.vr));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    {CS, RAS, CAS, WE} = 4'b1111;
    step(1'b0, P_NOP);
    step(1'b0, P_NOP);
    repeat (10) step(1'b1, 4'b1111);
    chk("idle_valid", 32'(cmd_valid), 0);
    chk("idle_count", 32'(ref_count), 0);

    busy_seen = 0; done_seen = 0;
    step(1'b1, P_REF);
    repeat (110) step(1'b1, P_NOP);
    chk("rfc_len", busy_seen, T_RFC);
    chk("rfc_done_cnt", done_seen, 1);
    chk("rfc_refcnt", 32'(ref_count), 1);
    chk("rfc_noviol", 32'({viol_cmd, viol_state, viol_illegal}), 0);

    busy_seen = 0;
    step(1'b1, P_REF);
    repeat (49) step(1'b1, P_NOP);
    step(1'b1, P_ACT);
    repeat (60) step(1'b1, P_DES);
    chk("act_busy_len", busy_seen, T_RFC);
    chk("act_viol_cmd", 32'(viol_cmd), 1);
    chk("act_row", 32'(row_open), 0);

    step(1'b0, P_NOP);
    step(1'b1, P_MRS);
    step(1'b1, P_ACT);
    step(1'b1, P_RD);
    step(1'b1, P_REF);
    chk("open_ref_row", 32'(row_open), 1);
    chk("open_ref_cnt", 32'(ref_count), 0);
    chk("open_ref_vs", 32'(viol_state), 1);
    step(1'b1, P_PRE);
    chk("pre_row", 32'(row_open), 0);
    step(1'b1, P_ILL);
    chk("ill_code", 32'(cmd_code), 7);
    chk("ill_flag", 32'(viol_illegal), 1);

    step(1'b0, P_NOP);
    step(1'b1, P_REF);
    repeat (T_RFC) step(1'b1, P_NOP);
    chk("b2b_done", 32'(ref_done), 1);
    step(1'b1, P_REF);
    chk("b2b_busy", 32'(ref_busy), 1);
    chk("b2b_cnt", 32'(ref_count), 2);
    chk("b2b_vc", 32'(viol_cmd), 0);

    repeat (20) step(1'b1, P_NOP);
    done_seen = 0;
    step(1'b0, P_NOP);
    chk("rst_busy", 32'(ref_busy), 0);
    chk("rst_cnt", 32'(ref_count), 0);
    repeat (120) step(1'b1, P_NOP);
    chk("rst_no_done", done_seen, 0);

`ifdef REF_INTERVAL_CHECK_EN
    step(1'b0, P_NOP);
    step(1'b1, P_REF);
    repeat (T_RFC + 30) step(1'b1, P_NOP);
    chk("refi_late", 32'(viol_refi), 1);
    step(1'b0, P_NOP);
    step(1'b1, P_REF);
    repeat (T_RFC + 15) step(1'b1, P_NOP);
    step(1'b1, P_REF);
    repeat (T_RFC + 10) step(1'b1, P_NOP);
    chk("refi_ok", 32'(viol_refi), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_cmd_decoder.md
Name: dram_cmd_decoder

Overview:
- Device-side receiver for the controller's DRAM command bus (CS, RAS, CAS, WE, all active-low), sampled every clk rising edge.
- Decodes each cycle into a command, tracks single-bank row state and refresh-busy windows, and flags protocol and timing violations.
- Sits in the memory-model/monitor path opposite the controller's refresh and access state machines. Used in simulation and as an on-FPGA protocol checker.

Parameters:
- T_RFC, 104, cycles after a REFRESH command during which only NOP/DESELECT are legal.
- T_REFI_MAX, 7800, maximum cycles allowed between REFRESH commands (used only with the optional feature).
- CNT_W, 16, width of the refresh counter and interval counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- CS  in  1  chip select, active-low.
- RAS  in  1  row strobe, active-low.
- CAS  in  1  column strobe, active-low.
- WE  in  1  write enable, active-low.
- cmd_valid  out  1  high when the cycle's decoded command is not DESELECT/NOP.
- cmd_code  out  3  decoded command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 ILLEGAL.
- row_open  out  1  bank has an open row.
- ref_busy  out  1  inside a tRFC window.
- ref_done  out  1  one-cycle pulse when a tRFC window completes.
- ref_count  out  CNT_W  REFRESH commands accepted; wraps modulo 2^CNT_W.
- viol_cmd  out  1  sticky: non-NOP command during ref_busy.
- viol_state  out  1  sticky: command illegal for bank state.
- viol_illegal  out  1  sticky: reserved encoding seen.

Behaviour:
- Registered outputs, one-cycle latency. Pins sampled at edge N appear on cmd_valid/cmd_code after edge N.
- Decode when CS=0, using {RAS,CAS,WE}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 000 REF, 001 MRS, 110 ILLEGAL. CS=1 decodes as NOP regardless of the other pins.
- Reset (rst_n=0 at an edge): state CLOSED; all outputs 0; ref_count 0; counters cleared. Reset mid-window aborts the window with no ref_done.
- FSM states:
  - CLOSED: ACT -> OPEN. REF -> REF_BUSY, timer loaded with T_RFC, ref_count+1. PRE is legal and stays CLOSED. MRS is legal. RD/WR -> viol_state, stay CLOSED.
  - OPEN: RD/WR stay. PRE -> CLOSED. ACT, REF or MRS -> viol_state. A REF here is not executed: no count increment, no state change.
  - REF_BUSY: timer decrements each cycle. Any decoded command other than NOP -> viol_cmd; the command is otherwise ignored. On the cycle the timer reaches 1, the next edge enters CLOSED and ref_done pulses for one cycle.
- ref_busy = (state == REF_BUSY). Exactly T_RFC cycles of ref_busy follow each accepted REF.
- Violation flags are sticky until reset. ILLEGAL sets viol_illegal in any state and causes no transition.
- A REF issued on the same cycle ref_done pulses is decoded in CLOSED and is legal: back-to-back windows with no gap.

Optional Feature:
- Macro: REF_INTERVAL_CHECK_EN.
- Defined: adds output viol_refi (1 bit, sticky) and a CNT_W interval counter.
  - Counter clears on each accepted REF and otherwise increments, saturating at all-ones.
  - viol_refi sets when the counter exceeds T_REFI_MAX.
  - Counter is held (does not increment) during ref_busy.
- Undefined: no counter, no viol_refi port; all other behaviour is identical.

Decomposition:
- Package dram_cmd_pkg holds:
  - the 3-bit command code constants (NOP..ILLEGAL);
  - the {RAS,CAS,WE} pin encodings;
  - the FSM state encodings, shared with the controller-side state machines so both ends use one table.
- One sub-module, dram_cmd_timer: a loadable down-counter with a done strike. Instantiated for tRFC, and for tREFI when the feature is enabled.

Test Plan:
- Reset, then pins all 1 for 10 cycles -> cmd_valid=0, row_open=0, all flags 0, ref_count=0.
- CS/RAS/CAS/WE=0000 for 1 cycle, then 0111 for 104 cycles -> ref_busy high for exactly 104 cycles, ref_done pulse once, ref_count=1, no violations.
- REF, then ACT (0011) at cycle 50 of the window -> viol_cmd=1, row_open stays 0, window still ends at cycle 104.
- ACT, RD (0101), REF (0000) -> viol_state=1, ref_count unchanged, row_open=1. Then PRE (0010) -> row_open=0.
- Pins 0110 -> cmd_code=7, viol_illegal=1. Assert rst_n=0 mid-refresh window -> all outputs 0 next cycle, no ref_done.
- With REF_INTERVAL_CHECK_EN and T_REFI_MAX=20: REF, then 30 idle cycles after the window -> viol_refi=1. Repeat with a REF at idle cycle 15 -> viol_refi stays 0.
